// File: rtl/serial_frame_ctrl_if.sv
// Bundles the frame-request side and the driven-machine side of serial_frame_ctrl.
// master: the requester / bench; slave: the controller itself.
interface serial_frame_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic             y_out;
  logic             x_in;
  logic             fsm_rstn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       state;

  modport master (
    output start, abort, data_in, y_out,
    input  x_in, fsm_rstn, busy, done, result, state
  );

  modport slave (
    input  start, abort, data_in, y_out,
    output x_in, fsm_rstn, busy, done, result, state
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serializes a latched word LSB-first into a single-bit sequential machine after a one-cycle
// clear, capturing that machine's y_out per bit into a parallel result.
module serial_frame_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rstn,
  serial_frame_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StClear = 2'b01;
  localparam logic [1:0] StShift = 2'b10;
  localparam logic [1:0] StDone  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        sreg_d = bus.data_in;
        cap_d  = '0;
        cnt_d  = '0;
        if (bus.start) state_d = StClear;
      end
      StClear: begin
        state_d = bus.abort ? StIdle : StShift;
      end
      StShift: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          cap_d[cnt_q] = bus.y_out;
          sreg_d       = sreg_q >> 1;
          cnt_d        = cnt_q + CntW'(1);
          // Final bit goes straight into result along with the earlier captures.
          if (cnt_q == CntLast) begin
            state_d  = StDone;
            result_d = cap_d;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      sreg_q   <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.x_in     = (state_q == StShift) & sreg_q[0];
  // Downstream machine is held in reset whenever this block is.
  assign bus.fsm_rstn = rstn & (state_q != StClear);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.result   = result_q;
  assign bus.state    = state_q;
endmodule
